change_dispenser: RTL and testbench
===================================

# change_dispenser

Downstream consumer of the vending machine's `prd`/`chng` outputs. It detects each vend event, converts the 2-bit change code into a count of Rs.5 coins, and pays them out one at a time through a req/ack handshake to the coin ejector. It also keeps a coin inventory counter, which can be refilled, and reports shortage and missed-vend conditions. It sits between `vending_machine` and the physical coin ejector.

## Interface
- `COIN_W`, 6: width of the inventory counter; max inventory is 2^COIN_W−1.
- `INIT_COINS`, 20: inventory value loaded on reset.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prd`  in  3  product code from the vending machine; 0 = no product, nonzero = product vended.
- `chng`  in  2  change code from the vending machine: 00=Rs.0, 01=Rs.5, 10=Rs.10, 11=Rs.15.
- `load_en`  in  1  inventory refill strobe.
- `load_val`  in  COIN_W  new inventory value.
- `eject_ack`  in  1  ejector acknowledge; one coin has been dropped.
- `eject_req`  out  1  request to eject one Rs.5 coin.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when payout of a vend event completes.
- `short_err`  out  1  sticky; inventory was insufficient for a requested payout.
- `missed`  out  1  sticky; a vend event arrived while busy and was dropped.
- `coins`  out  COIN_W  current inventory.

## Operation
- **Vend event:** `prd != 0` while registered `prd_q == 0`. `prd_q` resets to 0.
- **Coin count:** equals the `chng` value (0–3). At the event, `pending = min(chng, coins)`. If `chng > coins`, `short_err` is set.
- **FSM states:** IDLE, REQ, GAP, DONE.
- **IDLE:**
  - Vend event with `pending > 0` → REQ.
  - Vend event with `pending == 0` (including `chng == 00`) → DONE.
  - `load_en` with no vend event → `coins <= load_val`; `short_err` and `missed` are cleared.
  - If `load_en` and a vend event occur in the same cycle, the vend wins and the load is ignored.
- **REQ:** `eject_req = 1`. On `eject_ack == 1`: `coins -= 1`, `pending -= 1`, go to GAP.
- **GAP:** `eject_req = 0`. Wait for `eject_ack == 0`, then go to REQ if `pending > 0`, else to DONE.
- **DONE:** `done = 1` for exactly one cycle, then go to IDLE.
- **Ignored while not IDLE:**
  - A vend event sets `missed` and is discarded.
  - `load_en` is ignored entirely.
- **Underflow:** the inventory never decrements below 0, guaranteed by the `min` clamp.
- **Output encoding:** all outputs are registered or decoded directly from state. `eject_req = (state == REQ)`; `busy = (state != IDLE)`.

## Timing
- **Reset values:** state IDLE, `eject_req = 0`, `busy = 0`, `done = 0`, `short_err = 0`, `missed = 0`, `coins = INIT_COINS`, `pending = 0`, `prd_q = 0`.
- **Reset mid-payout:** aborts the payout at the next edge. No further coins are ejected, and `coins` returns to INIT_COINS.
- **Event detection:** the event is sampled at edge N. `busy` and `eject_req` (if `pending > 0`) are high from N+1.
- **Ack response:** an ack sampled at edge M causes `eject_req` to drop and `coins` to update at M+1.
- **Minimum cycles per coin:** 2 (REQ + GAP), reached when the ack is high for exactly one cycle.
- **Zero-change event:** `done` is high in cycle N+1 and `busy` is high for that one cycle only.
- **Payout of k coins with a 1-cycle ack each time:** `done` is asserted at N+2k+1, and `busy` clears at N+2k+2.
- **Holding `prd` nonzero across cycles:** produces only one event. A new event requires `prd` to return to 0 for at least one cycle.
- **Ack outside REQ:** `eject_ack` high in IDLE or DONE has no effect.

## Test plan
- **Reset state:** assert `rst` for 2 cycles → `coins = 20`, all flags 0, `eject_req = 0`.
- **Rs.15 item, three Rs.5 notes:** `prd` 0→3 with `chng = 00` → no `eject_req`, `done` pulses 1 cycle later, `coins` stays 20.
- **Rs.15 change:** `prd` 0→1 with `chng = 11`, ejector acks each req after 1 cycle → exactly 3 `eject_req` pulses, `done` once, `coins = 17`, `short_err = 0`.
- **Shortage:** `load_en` with `load_val = 1`, then a vend with `chng = 10` → 1 coin ejected, `coins = 0`, `short_err = 1`. A later `load_en` with `load_val = 5` → `coins = 5`, `short_err = 0`.
- **Overlapping vend:** during a 2-coin payout with a slow ack (3 cycles), toggle `prd` 0→2 → `missed = 1`, still exactly 2 coins paid. A `load_en` issued during the payout is ignored.
- **Reset mid-payout:** assert `rst` while in REQ during a 3-coin payout → `eject_req = 0` next cycle, state IDLE, `coins = 20`, no further reqs.

Source files
------------

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out Rs.5 coins per vend event over a req/ack ejector handshake
module change_dispenser #(
  parameter int COIN_W     = 6,
  parameter int INIT_COINS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        prd,
  input  logic [1:0]        chng,
  input  logic              load_en,
  input  logic [COIN_W-1:0] load_val,
  input  logic              eject_ack,
  output logic              eject_req,
  output logic              busy,
  output logic              done,
  output logic              short_err,
  output logic              missed,
  output logic [COIN_W-1:0] coins
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        pending_q, pending_d;
  logic [COIN_W-1:0] coins_q, coins_d;
  logic [2:0]        prd_q, prd_d;
  logic              short_err_q, short_err_d;
  logic              missed_q, missed_d;

  logic              vend_ev;
  logic              short_now;
  logic [1:0]        pay_cnt;

  // Rising edge of "product present"; a held nonzero prd yields one event.
  assign vend_ev   = (prd != 3'd0) && (prd_q == 3'd0);
  assign short_now = COIN_W'(chng) > coins_q;
  // When short, coins_q is below chng (at most 2), so its low bits hold it exactly.
  assign pay_cnt   = short_now ? coins_q[1:0] : chng;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    coins_d     = coins_q;
    short_err_d = short_err_q;
    missed_d    = missed_q;
    prd_d       = prd;

    case (state_q)
      S_IDLE: begin
        if (vend_ev) begin
          pending_d = pay_cnt;
          if (short_now) short_err_d = 1'b1;
          state_d = (pay_cnt != 2'd0) ? S_REQ : S_DONE;
        end else if (load_en) begin
          coins_d     = load_val;
          short_err_d = 1'b0;
          missed_d    = 1'b0;
        end
      end
      S_REQ: begin
        if (eject_ack) begin
          coins_d   = coins_q - 1'b1;
          pending_d = pending_q - 2'd1;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (!eject_ack) state_d = (pending_q != 2'd0) ? S_REQ : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (vend_ev && (state_q != S_IDLE)) missed_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pending_q   <= 2'd0;
      coins_q     <= COIN_W'(INIT_COINS);
      prd_q       <= 3'd0;
      short_err_q <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      coins_q     <= coins_d;
      prd_q       <= prd_d;
      short_err_q <= short_err_d;
      missed_q    <= missed_d;
    end
  end

  assign eject_req = (state_q == S_REQ);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign short_err = short_err_q;
  assign missed    = missed_q;
  assign coins     = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - vector table plus scoreboard bench for change_dispenser
module tb_change_dispenser;

  localparam int COIN_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        prd = 3'd0;
  logic [1:0]        chng = 2'd0;
  logic              load_en = 1'b0;
  logic [COIN_W-1:0] load_val = '0;
  logic              eject_ack;
  logic              eject_req, busy, done, short_err, missed;
  logic [COIN_W-1:0] coins;

  logic model_ack = 1'b0;
  logic idle_ack  = 1'b0;
  int   ack_dly   = 1;
  int   req_age   = 0;
  logic req_prev  = 1'b0;
  int   pulse_cnt = 0;
  int   cyc       = 0;

  int total = 0;
  int bad   = 0;

  assign eject_ack = model_ack | idle_ack;

  change_dispenser #(.COIN_W(COIN_W), .INIT_COINS(20)) dut (
    .clk(clk), .rst(rst), .prd(prd), .chng(chng),
    .load_en(load_en), .load_val(load_val), .eject_ack(eject_ack),
    .eject_req(eject_req), .busy(busy), .done(done),
    .short_err(short_err), .missed(missed), .coins(coins)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ejector model: ack after ack_dly cycles of req, held one cycle; counts req pulses.
  always @(negedge clk) begin
    if (model_ack) model_ack = 1'b0;
    else if (eject_req) begin
      req_age = req_age + 1;
      if (req_age >= ack_dly) begin
        model_ack = 1'b1;
        req_age   = 0;
      end
    end else req_age = 0;
    if (eject_req && !req_prev) pulse_cnt = pulse_cnt + 1;
    req_prev = eject_req;
  end

  typedef struct {
    logic       do_load;
    int         lval;
    logic [2:0] p;
    logic [1:0] c;
    int         dly;
    int         paid;
    int         coins_after;
    int         short_after;
  } vec_t;

  typedef struct {
    int paid;
    int coins_after;
    int short_after;
    int lat;
    int base;
    int start;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_vend(input logic [2:0] p, input logic [1:0] c, input int paid,
                           input int ca, input int sa, input int dly);
    exp_t e;
    ack_dly = dly;
    prd  = p;
    chng = c;
    e.paid = paid; e.coins_after = ca; e.short_after = sa;
    e.lat = paid * (dly + 1) + 1;
    e.base = pulse_cnt;
    e.start = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done_and_check(input string tag);
    exp_t e;
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 0) prd = 3'd0;
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done want done", tag);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk({tag, "_paid"}, pulse_cnt - e.base, e.paid);
    chk({tag, "_coins"}, int'(coins), e.coins_after);
    chk({tag, "_short"}, int'(short_err), e.short_after);
    chk({tag, "_latency"}, cyc - e.start, e.lat);
    tick();
    chk({tag, "_done_1cyc"}, int'(done), 0);
    chk({tag, "_busy_clear"}, int'(busy), 0);
  endtask

  initial begin
    int base;
    int dones;
    bit seen;

    vecs[0] = '{1'b0, 0,  3'd3, 2'd0, 1, 0, 20, 0};
    vecs[1] = '{1'b0, 0,  3'd1, 2'd3, 1, 3, 17, 0};
    vecs[2] = '{1'b0, 0,  3'd2, 2'd1, 2, 1, 16, 0};
    vecs[3] = '{1'b1, 1,  3'd5, 2'd2, 1, 1, 0,  1};
    vecs[4] = '{1'b1, 5,  3'd7, 2'd0, 1, 0, 5,  0};
    vecs[5] = '{1'b0, 0,  3'd4, 2'd2, 3, 2, 3,  0};
    vecs[6] = '{1'b1, 2,  3'd6, 2'd3, 1, 2, 0,  1};
    vecs[7] = '{1'b0, 0,  3'd1, 2'd1, 1, 0, 0,  1};
    vecs[8] = '{1'b1, 63, 3'd2, 2'd3, 2, 3, 60, 0};

    tick(); tick();
    chk("rst_coins", int'(coins), 20);
    chk("rst_req", int'(eject_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short", int'(short_err), 0);
    chk("rst_missed", int'(missed), 0);
    rst = 1'b0;

    idle_ack = 1'b1;
    tick(); tick(); tick();
    idle_ack = 1'b0;
    chk("idle_ack_coins", int'(coins), 20);
    chk("idle_ack_busy", int'(busy), 0);
    tick();

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_load) begin
        load_en  = 1'b1;
        load_val = COIN_W'(vecs[i].lval);
        tick();
        load_en = 1'b0;
        chk($sformatf("v%0d_load", i), int'(coins), vecs[i].lval);
        chk($sformatf("v%0d_load_short", i), int'(short_err), 0);
      end
      push_vend(vecs[i].p, vecs[i].c, vecs[i].paid, vecs[i].coins_after,
                vecs[i].short_after, vecs[i].dly);
      wait_done_and_check($sformatf("v%0d", i));
      tick();
    end

    // Holding prd nonzero must yield one event only.
    base = pulse_cnt;
    prd = 3'd4; chng = 2'd0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dones++;
    end
    prd = 3'd0;
    tick();
    chk("hold_done_count", dones, 1);
    chk("hold_missed", int'(missed), 0);

    // Overlapping vend and ignored load during a slow 2-coin payout.
    push_vend(3'd1, 2'd2, 2, 58, 0, 3);
    tick(); prd = 3'd0;
    tick();
    prd = 3'd2;
    load_en = 1'b1; load_val = 6'd7;
    tick();
    prd = 3'd0;
    load_en = 1'b0;
    chk("ovl_busy", int'(busy), 1);
    chk("ovl_missed", int'(missed), 1);
    wait_done_and_check("ovl");
    chk("ovl_missed_sticky", int'(missed), 1);
    load_en = 1'b1; load_val = 6'd10;
    tick();
    load_en = 1'b0;
    chk("ovl_reload_coins", int'(coins), 10);
    chk("ovl_reload_missed", int'(missed), 0);
    tick();

    // Reset in the middle of a 3-coin payout.
    base = pulse_cnt;
    ack_dly = 3;
    prd = 3'd3; chng = 2'd3;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      prd = 3'd0;
      if (eject_req && (pulse_cnt - base == 2)) begin seen = 1'b1; break; end
    end
    chk("mid_reached_req2", int'(seen), 1);
    rst = 1'b1;
    tick();
    chk("mid_req_drop", int'(eject_req), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_coins", int'(coins), 20);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dones++;
    end
    chk("mid_no_more_reqs", pulse_cnt - base, 2);
    chk("mid_no_done", dones, 0);
    chk("mid_coins_hold", int'(coins), 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
